code_frame_collector: RTL and testbench

- Sits directly downstream of the ASCII-to-code stage and consumes its 5-bit symbol codes.
- Assembles accepted codes into one frame buffer: an input line of terms separated by '+' and ended by Enter.
- Syntax-checks the line, then holds the completed frame for the minimization core to read by address.
- Releases the buffer on frame_ack.

---
 rtl/code_frame_collector_pkg.sv | 44 ++++
 rtl/code_frame_collector_if.sv | 41 ++++
 rtl/code_frame_collector_classifier.sv | 43 ++++
 rtl/code_frame_collector.sv | 227 ++++++++++++++++++++++
 tb/tb_code_frame_collector.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/code_frame_collector_pkg.sv
// -----------------------------------------------------------------------------
// code_frame_pkg
// Shared symbol-code constants, FSM state and error encodings for the
// code_frame_collector block and its classifier.
//   CODE_ENTER / CODE_PLUS   : line terminator and term separator codes
//   DIGIT_* / LOWER_* / UPPER_* : inclusive operand code ranges
//   state_t                  : collector FSM states
//   err_t                    : err_code encoding driven on the frame bus
// -----------------------------------------------------------------------------
package code_frame_pkg;

  localparam logic [4:0] CODE_ENTER  = 5'd16;
  localparam logic [4:0] CODE_PLUS   = 5'd17;
  localparam logic [4:0] DIGIT_LO    = 5'd1;
  localparam logic [4:0] DIGIT_HI    = 5'd5;
  localparam logic [4:0] LOWER_LO    = 5'd10;
  localparam logic [4:0] LOWER_HI    = 5'd14;
  localparam logic [4:0] UPPER_LO    = 5'd26;
  localparam logic [4:0] UPPER_HI    = 5'd30;
  // Distance from a lower-case code to its upper-case counterpart.
  localparam logic [4:0] FOLD_OFFSET = 5'd16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2,
    ERROR   = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_ILLEGAL  = 2'd1,
    ERR_SYNTAX   = 2'd2,
    ERR_OVERFLOW = 2'd3
  } err_t;

  // Inclusive range test on a 5-bit code.
  function automatic logic in_range(input logic [4:0] v,
                                    input logic [4:0] lo,
                                    input logic [4:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/code_frame_collector_if.sv
// -----------------------------------------------------------------------------
// code_frame_collector_if
// Bundles the symbol input handshake and the frame read-out bus.
//   code_valid/code/code_ready : symbol stream from the ASCII-to-code stage
//   frame_valid/frame_len/term_count/err/err_code : frame status
//   rd_addr/rd_data            : registered frame buffer read port
//   frame_ack                  : consumer releases the held frame
// Modports: slave  = the collector
//           master = upstream stage plus minimization core (or a bench)
// -----------------------------------------------------------------------------
interface code_frame_collector_if #(
  parameter int DEPTH     = 16,
  parameter int MAX_TERMS = 8
);
  localparam int LEN_W  = $clog2(DEPTH + 1);
  localparam int TERM_W = $clog2(MAX_TERMS + 1);
  localparam int ADDR_W = $clog2(DEPTH);

  logic              code_valid;
  logic [4:0]        code;
  logic              code_ready;
  logic              frame_valid;
  logic [LEN_W-1:0]  frame_len;
  logic [TERM_W-1:0] term_count;
  logic [ADDR_W-1:0] rd_addr;
  logic [4:0]        rd_data;
  logic              frame_ack;
  logic              err;
  logic [1:0]        err_code;

  modport slave (
    input  code_valid, code, rd_addr, frame_ack,
    output code_ready, frame_valid, frame_len, term_count, rd_data, err, err_code
  );

  modport master (
    output code_valid, code, rd_addr, frame_ack,
    input  code_ready, frame_valid, frame_len, term_count, rd_data, err, err_code
  );

endinterface

// File: rtl/code_frame_collector_classifier.sv
// -----------------------------------------------------------------------------
// code_classifier
// Purely combinational decode of one 5-bit symbol code.
//   code_i       : incoming symbol code
//   is_operand_o : digit 1-5, lower a-e (10-14) or upper A-E (26-30)
//   is_plus_o    : term separator '+'
//   is_enter_o   : line terminator
//   is_illegal_o : any other value
//   store_code_o : value to write into the frame buffer
// Build option COLLECTOR_CASE_FOLD_EN: when defined, lower-case letters are
// stored as their upper-case codes so the core sees one variable alphabet;
// otherwise codes are stored unchanged.
// -----------------------------------------------------------------------------
module code_classifier
  import code_frame_pkg::*;
(
  input  logic [4:0] code_i,
  output logic       is_operand_o,
  output logic       is_plus_o,
  output logic       is_enter_o,
  output logic       is_illegal_o,
  output logic [4:0] store_code_o
);

  logic is_digit;
  logic is_lower;
  logic is_upper;

  assign is_digit     = in_range(code_i, DIGIT_LO, DIGIT_HI);
  assign is_lower     = in_range(code_i, LOWER_LO, LOWER_HI);
  assign is_upper     = in_range(code_i, UPPER_LO, UPPER_HI);
  assign is_operand_o = is_digit || is_lower || is_upper;
  assign is_plus_o    = (code_i == CODE_PLUS);
  assign is_enter_o   = (code_i == CODE_ENTER);
  assign is_illegal_o = !(is_operand_o || is_plus_o || is_enter_o);

`ifdef COLLECTOR_CASE_FOLD_EN
  assign store_code_o = is_lower ? (code_i + FOLD_OFFSET) : code_i;
`else
  assign store_code_o = code_i;
`endif

endmodule

// File: rtl/code_frame_collector.sv
// -----------------------------------------------------------------------------
// code_frame_collector
// Collects accepted symbol codes into a frame buffer forming one line of
// '+'-separated terms ended by Enter, syntax-checks it, then holds the frame
// for the minimization core to read by address until frame_ack.
//   clk   : system clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : code_frame_collector_if.slave (symbol input, frame status, read port)
// Parameters: DEPTH symbol slots (separators stored, Enter not),
//             MAX_TERMS maximum terms per frame.
// Build option COLLECTOR_CASE_FOLD_EN: fold lower-case letters to upper-case
// codes before storage (handled in code_classifier).
// -----------------------------------------------------------------------------
module code_frame_collector
  import code_frame_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int MAX_TERMS = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  code_frame_collector_if.slave   bus
);

  localparam int LEN_W  = $clog2(DEPTH + 1);
  localparam int TERM_W = $clog2(MAX_TERMS + 1);
  localparam int ADDR_W = $clog2(DEPTH);

  localparam logic [LEN_W-1:0]  LEN_FULL  = LEN_W'(DEPTH);
  localparam logic [TERM_W-1:0] TERM_FULL = TERM_W'(MAX_TERMS);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t            state_q,      state_d;
  logic [LEN_W-1:0]  frame_len_q,  frame_len_d;
  logic [TERM_W-1:0] term_count_q, term_count_d;
  logic              after_plus_q, after_plus_d;   // last stored symbol was '+'
  logic              err_q,        err_d;
  err_t              err_code_q,   err_code_d;
  logic [4:0]        rd_data_q;

  logic [4:0]        frame_mem [DEPTH];
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;

  // ---------------------------------------------------------------------------
  // Symbol decode
  // ---------------------------------------------------------------------------
  logic       cls_operand;
  logic       cls_plus;
  logic       cls_enter;
  logic       cls_illegal;
  logic [4:0] cls_store;

  code_classifier u_classifier (
    .code_i       (bus.code),
    .is_operand_o (cls_operand),
    .is_plus_o    (cls_plus),
    .is_enter_o   (cls_enter),
    .is_illegal_o (cls_illegal),
    .store_code_o (cls_store)
  );

  logic code_ready;
  logic accept;

  // The upstream stage holds its code while a frame is waiting for the core.
  assign code_ready = (state_q != DONE);
  assign accept     = bus.code_valid && code_ready;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    frame_len_d  = frame_len_q;
    term_count_d = term_count_q;
    after_plus_d = after_plus_q;
    err_d        = err_q;
    err_code_d   = err_code_q;
    wr_en        = 1'b0;
    wr_addr      = ADDR_W'(frame_len_q);

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (cls_illegal) begin
            state_d    = ERROR;
            err_d      = 1'b1;
            err_code_d = ERR_ILLEGAL;
          end else if (cls_operand) begin
            // First operand opens a new line and clears any held error.
            wr_en        = 1'b1;
            wr_addr      = '0;
            frame_len_d  = LEN_W'(1);
            term_count_d = TERM_W'(1);
            after_plus_d = 1'b0;
            err_d        = 1'b0;
            err_code_d   = ERR_NONE;
            state_d      = COLLECT;
          end else if (cls_plus) begin
            state_d    = ERROR;
            err_d      = 1'b1;
            err_code_d = ERR_SYNTAX;
          end
          // Enter on an empty line is silently dropped.
        end
      end

      COLLECT: begin
        if (accept) begin
          if (cls_illegal) begin
            state_d    = ERROR;
            err_d      = 1'b1;
            err_code_d = ERR_ILLEGAL;
          end else if (cls_operand) begin
            // An operand after '+' opens a new term; that is where the term
            // limit is enforced.
            if ((frame_len_q == LEN_FULL) ||
                (after_plus_q && (term_count_q == TERM_FULL))) begin
              state_d    = ERROR;
              err_d      = 1'b1;
              err_code_d = ERR_OVERFLOW;
            end else begin
              wr_en        = 1'b1;
              frame_len_d  = frame_len_q + LEN_W'(1);
              after_plus_d = 1'b0;
              if (after_plus_q) begin
                term_count_d = term_count_q + TERM_W'(1);
              end
            end
          end else if (cls_plus) begin
            if (after_plus_q) begin
              state_d    = ERROR;
              err_d      = 1'b1;
              err_code_d = ERR_SYNTAX;
            end else if (frame_len_q == LEN_FULL) begin
              state_d    = ERROR;
              err_d      = 1'b1;
              err_code_d = ERR_OVERFLOW;
            end else begin
              wr_en        = 1'b1;
              frame_len_d  = frame_len_q + LEN_W'(1);
              after_plus_d = 1'b1;
            end
          end else begin
            // Enter: a dangling '+' leaves an empty last term.
            if (after_plus_q) begin
              state_d    = ERROR;
              err_d      = 1'b1;
              err_code_d = ERR_SYNTAX;
            end else begin
              state_d = DONE;
            end
          end
        end
      end

      DONE: begin
        if (bus.frame_ack) begin
          state_d      = IDLE;
          frame_len_d  = '0;
          term_count_d = '0;
          after_plus_d = 1'b0;
        end
      end

      ERROR: begin
        // Everything up to Enter is discarded; err/err_code stay latched so
        // the first detected error is what software sees.
        if (accept && cls_enter) begin
          state_d      = IDLE;
          frame_len_d  = '0;
          term_count_d = '0;
          after_plus_d = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      frame_len_q  <= '0;
      term_count_q <= '0;
      after_plus_q <= 1'b0;
      err_q        <= 1'b0;
      err_code_q   <= ERR_NONE;
      rd_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      frame_len_q  <= frame_len_d;
      term_count_q <= term_count_d;
      after_plus_q <= after_plus_d;
      err_q        <= err_d;
      err_code_q   <= err_code_d;
      rd_data_q    <= frame_mem[bus.rd_addr];
    end
  end

  // Buffer storage carries no reset so it maps onto block/distributed RAM.
  always_ff @(posedge clk) begin
    if (rst_n && wr_en) begin
      frame_mem[wr_addr] <= cls_store;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.code_ready  = code_ready;
  assign bus.frame_valid = (state_q == DONE);
  assign bus.frame_len   = frame_len_q;
  assign bus.term_count  = term_count_q;
  assign bus.rd_data     = rd_data_q;
  assign bus.err         = err_q;
  assign bus.err_code    = err_code_q;

endmodule

// File: tb/tb_code_frame_collector.sv
// -----------------------------------------------------------------------------
// tb_code_frame_collector
// Directed-vector bench for code_frame_collector (DEPTH=16, MAX_TERMS=8).
// Expected values are hand-derived; the lower-case expectation follows the
// COLLECTOR_CASE_FOLD_EN build option.
// -----------------------------------------------------------------------------
module tb_code_frame_collector;

  localparam int DEPTH     = 16;
  localparam int MAX_TERMS = 8;

`ifdef COLLECTOR_CASE_FOLD_EN
  localparam int EXP_LOWER_B = 27;
  localparam int EXP_LOWER_A = 26;
`else
  localparam int EXP_LOWER_B = 11;
  localparam int EXP_LOWER_A = 10;
`endif

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  code_frame_collector_if #(.DEPTH(DEPTH), .MAX_TERMS(MAX_TERMS)) bus ();

  code_frame_collector #(.DEPTH(DEPTH), .MAX_TERMS(MAX_TERMS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present one code and hold it until accepted (bounded wait).
  task automatic send(input logic [4:0] c);
    int waited;
    waited = 0;
    @(negedge clk);
    bus.code_valid = 1'b1;
    bus.code       = c;
    while (!bus.code_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.code_ready) begin
      check("send_timeout", 32'(bus.code_ready), 1);
      bus.code_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    bus.code_valid = 1'b0;
    $display("send code=%0d state=%0d len=%0d terms=%0d err=%0d err_code=%0d",
             c, dut.state_q, bus.frame_len, bus.term_count, bus.err, bus.err_code);
  endtask

  task automatic read_chk(input string tag, input int addr, input int exp);
    @(negedge clk);
    bus.rd_addr = 4'(addr);
    @(posedge clk);
    #1;
    $display("read addr=%0d data=%0d", addr, bus.rd_data);
    check(tag, 32'(bus.rd_data), 32'(exp));
  endtask

  task automatic ack();
    @(negedge clk);
    bus.frame_ack = 1'b1;
    @(posedge clk);
    #1;
    bus.frame_ack = 1'b0;
    $display("ack frame_valid=%0d", bus.frame_valid);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"},  32'(bus.code_ready),  1);
    check({tag, "_fvalid"}, 32'(bus.frame_valid), 0);
    check({tag, "_len"},    32'(bus.frame_len),   0);
    check({tag, "_terms"},  32'(bus.term_count),  0);
    check({tag, "_rdata"},  32'(bus.rd_data),     0);
    check({tag, "_err"},    32'(bus.err),         0);
    check({tag, "_ecode"},  32'(bus.err_code),    0);
  endtask

  initial begin
    n_checks       = 0;
    n_fail         = 0;
    rst_n          = 1'b0;
    bus.code_valid = 1'b0;
    bus.code       = '0;
    bus.rd_addr    = '0;
    bus.frame_ack  = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // "A+b1" Enter
    send(5'd26); send(5'd17); send(5'd11); send(5'd1); send(5'd16);
    check("f1_valid", 32'(bus.frame_valid), 1);
    check("f1_len",   32'(bus.frame_len),   4);
    check("f1_terms", 32'(bus.term_count),  2);
    check("f1_ready", 32'(bus.code_ready),  0);
    check("f1_err",   32'(bus.err),         0);
    read_chk("f1_rd0", 0, 26);
    read_chk("f1_rd1", 1, 17);
    read_chk("f1_rd2", 2, EXP_LOWER_B);
    read_chk("f1_rd3", 3, 1);

    // Hold a code while DONE: not accepted, buffer untouched
    @(negedge clk);
    bus.code_valid = 1'b1;
    bus.code       = 5'd3;
    check("done_ready", 32'(bus.code_ready), 0);
    repeat (3) @(posedge clk);
    #1;
    check("done_len_stable", 32'(bus.frame_len), 4);
    read_chk("done_rd0", 0, 26);
    read_chk("done_rd3", 3, 1);
    ack();
    check("ack_fvalid", 32'(bus.frame_valid), 0);
    check("ack_ready",  32'(bus.code_ready),  1);
    check("ack_len",    32'(bus.frame_len),   0);
    @(posedge clk);
    #1;
    bus.code_valid = 1'b0;
    $display("held code=3 accepted len=%0d", bus.frame_len);
    check("held_len",   32'(bus.frame_len),  1);
    check("held_terms", 32'(bus.term_count), 1);
    send(5'd16);
    check("f2_valid", 32'(bus.frame_valid), 1);
    read_chk("f2_rd0", 0, 3);
    ack();

    // Empty line and leading '+'
    send(5'd16);
    check("empty_fvalid", 32'(bus.frame_valid), 0);
    check("empty_err",    32'(bus.err),         0);
    check("empty_ready",  32'(bus.code_ready),  1);
    check("empty_state",  32'(dut.state_q),     0);
    send(5'd17);
    check("lead_plus_err",   32'(bus.err),      1);
    check("lead_plus_ecode", 32'(bus.err_code), 2);
    send(5'd16);
    check("lead_plus_held", 32'(bus.err), 1);

    // Trailing '+', discard until Enter, then a clean line
    send(5'd1);
    check("newline_err_clr", 32'(bus.err), 0);
    send(5'd17); send(5'd16);
    check("trail_err",   32'(bus.err),      1);
    check("trail_ecode", 32'(bus.err_code), 2);
    send(5'd5); send(5'd7);
    check("trail_first_wins", 32'(bus.err_code), 2);
    check("trail_fvalid",     32'(bus.frame_valid), 0);
    send(5'd16);
    send(5'd2); send(5'd16);
    check("f3_valid", 32'(bus.frame_valid), 1);
    check("f3_len",   32'(bus.frame_len),   1);
    check("f3_terms", 32'(bus.term_count),  1);
    check("f3_err",   32'(bus.err),         0);
    read_chk("f3_rd0", 0, 2);
    ack();

    // Buffer overflow on the 17th symbol
    for (int i = 0; i < 16; i++) send(5'(1 + (i % 5)));
    check("full_len", 32'(bus.frame_len), 16);
    check("full_err", 32'(bus.err),       0);
    send(5'd3);
    check("ovf_err",   32'(bus.err),      1);
    check("ovf_ecode", 32'(bus.err_code), 3);
    send(5'd16);
    check("ovf_idle_ready",  32'(bus.code_ready),  1);
    check("ovf_idle_fvalid", 32'(bus.frame_valid), 0);
    check("ovf_idle_state",  32'(dut.state_q),     0);

    // Illegal code mid-line
    send(5'd1); send(5'd7);
    check("illegal_ecode", 32'(bus.err_code), 1);
    send(5'd16);

    // Term limit: eight terms fit, the ninth is rejected
    for (int i = 0; i < 8; i++) begin
      if (i > 0) send(5'd17);
      send(5'(1 + (i % 5)));
    end
    check("eight_terms", 32'(bus.term_count), 8);
    check("eight_len",   32'(bus.frame_len),  15);
    send(5'd17); send(5'd4);
    check("term_ovf_ecode", 32'(bus.err_code), 3);
    send(5'd16);

    // Double '+'
    send(5'd30); send(5'd17); send(5'd17);
    check("dbl_plus_ecode", 32'(bus.err_code), 2);
    send(5'd16);

    // Lower-case storage
    send(5'd10); send(5'd16);
    check("lower_valid", 32'(bus.frame_valid), 1);
    read_chk("lower_rd0", 0, EXP_LOWER_A);
    ack();

    // Reset mid-line
    send(5'd1); send(5'd17); send(5'd2);
    check("pre_rst_len", 32'(bus.frame_len), 3);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    rst_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
